// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
//
// Two-requester round-robin front end for a shared WIDTH-bit adder/subtractor.
// One operation is in flight at a time: it is accepted in IDLE, computed in
// EXEC, and presented in RESP until the consumer takes it.
//
// Ports
//   clk                  clock, rising-edge
//   rst                  asynchronous active-high reset
//   reqN_valid           requester N has an operation pending (N = 0, 1)
//   reqN_a, reqN_b       requester N operands (WIDTH bits)
//   reqN_op              0 = a + b, 1 = a - b
//   reqN_ready           requester N accepted this cycle (IDLE only)
//   rsp_valid            rsp_* carries a valid result
//   rsp_id               index of the requester owning the result
//   rsp_result           sum/difference modulo 2^WIDTH
//   rsp_cout             carry-out; for subtract 1 means a >= b (no borrow)
//   rsp_ready            consumer takes the result this cycle
// ---------------------------------------------------------------------------
module addsub_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             req1_ready,

    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    input  logic             rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             id_q;
    logic             last_grant;   // requester whose operation completed last

    logic             grant_any;
    logic             grant_id;
    logic [WIDTH:0]   sum;

    // Round-robin pick: on contention the requester not served last wins;
    // a lone requester always wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        grant_any = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else if (req1_valid)
            grant_id = 1'b1;
    end

    // Ready is combinational so the grant is visible in the accepting cycle;
    // gating with rst keeps it low while reset is held.
    assign req0_ready = !rst && (state == IDLE) && grant_any && !grant_id;
    assign req1_ready = !rst && (state == IDLE) && grant_any &&  grant_id;

    // Subtract as a + ~b + 1, so the carry-out doubles as "no borrow".
    assign sum = {1'b0, a_q} + {1'b0, (op_q ? ~b_q : b_q)} + {{WIDTH{1'b0}}, op_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;         // makes requester 0 win the first tie
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_q   <= grant_id ? req1_a  : req0_a;
                        b_q   <= grant_id ? req1_b  : req0_b;
                        op_q  <= grant_id ? req1_op : req0_op;
                        id_q  <= grant_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands come from the latched copies, so requester
                    // inputs changing after acceptance cannot disturb this.
                    {rsp_cout, rsp_result} <= sum;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-006 req0_op  input  1  requester 0 opcode: 0 = a+b, 1 = a-b.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_op, req1_ready  same widths and meanings for requester 1.
REQ-009 rsp_valid  output  1  result held on rsp_* is valid.
REQ-010 rsp_id  output  1  requester index owning the current result.
REQ-011 rsp_result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-012 rsp_cout  output  1  carry-out; for subtract, 1 = no borrow (a >= b unsigned).
REQ-013 rsp_ready  input  1  consumer accepts the result this cycle.

Function
REQ-014 The block SHALL implement three states: IDLE, EXEC, RESP.
REQ-015 IDLE: with no reqN_valid, stay IDLE; all reqN_ready = 0.
REQ-016 IDLE with at least one reqN_valid: grant exactly one requester, assert its reqN_ready combinationally in that cycle, latch its a, b, op and index, go to EXEC.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; a single valid requester is granted regardless of history.
REQ-018 reqN_ready SHALL be 0 in EXEC and RESP; at most one reqN_ready high in any cycle.
REQ-019 EXEC: compute {cout, result} = a + (op ? ~b : b) + op over WIDTH+1 bits, register into rsp_result/rsp_cout, go to RESP.
REQ-020 RESP: rsp_valid = 1; rsp_id, rsp_result, rsp_cout held stable until rsp_ready = 1.
REQ-021 RESP with rsp_ready = 1: handshake completes that cycle, update last-grant to rsp_id, go to IDLE next cycle.
REQ-022 Latency: operation accepted in cycle N yields rsp_valid in cycle N+2; minimum issue interval 3 cycles.
REQ-023 rsp_ready while not in RESP SHALL be ignored.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH; 0 - 1 gives all-ones with rsp_cout = 0; all-ones + 1 gives 0 with rsp_cout = 1.
REQ-025 Operand changes on reqN_* after acceptance SHALL NOT affect the in-flight result.
REQ-026 Requester dropping reqN_valid before grant SHALL be legal; no operation recorded for it.

Reset
REQ-027 rst high SHALL immediately force state IDLE, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_cout = 0, all reqN_ready = 0.
REQ-028 Reset SHALL set last-grant so requester 0 wins the first simultaneous request.
REQ-029 Reset in EXEC or RESP SHALL discard the in-flight operation; no response issued for it after reset release.

Verification
REQ-030 Reset, both valid, req0 = 5+3, req1 = 10-4, rsp_ready tied 1 -> first rsp_id 0 result 8 cout 0; next rsp_id 1 result 6 cout 1.
REQ-031 req0 only, 0x0000 - 0x0001 -> rsp_result 0xFFFF, rsp_cout 0, rsp_valid exactly 2 cycles after req0_ready.
REQ-032 req1 only, 0xFFFF + 0x0001 -> rsp_result 0x0000, rsp_cout 1, rsp_id 1.
REQ-033 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_* stable 5 cycles, no reqN_ready asserted, IDLE after rsp_ready.
REQ-034 Both valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-035 Assert rst during RESP holding 0x1234 -> outputs zero within the same cycle, no rsp_valid after release until a new request is accepted.
